// File: rtl/conv_window_gen.sv
// conv_window_gen: buffers three raster rows and emits stride-2 4x4 pixel windows
// for the downstream 3x3-conv / ReLU / 2x2-maxpool MAC stage.
module conv_window_gen #(
    parameter int IMG_W = 16,
    parameter int IMG_H = 16
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         i_start,
    input  logic         vld_i,
    input  logic [7:0]   i_pix,
    output logic         vld_o,
    output logic [127:0] o_win,
    output logic [7:0]   o_row_idx,
    output logic [7:0]   o_col_idx,
    output logic         o_frame_done
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] C_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] R_LAST = RW'(IMG_H - 1);

    logic [CW-1:0]    r_col, w_c;
    logic [RW-1:0]    r_row, w_r;
    logic [7:0]       r_lb0 [IMG_W];
    logic [7:0]       r_lb1 [IMG_W];
    logic [7:0]       r_lb2 [IMG_W];
    logic [15:0][7:0] r_win, w_nxt;
    logic [3:0][7:0]  w_new;
    logic             w_emit, w_last;

    // i_start makes the current pixel (0,0) without waiting a cycle
    assign w_c    = i_start ? '0 : r_col;
    assign w_r    = i_start ? '0 : r_row;
    assign w_new  = {i_pix, r_lb0[w_c], r_lb1[w_c], r_lb2[w_c]};
    assign w_emit = vld_i && w_r >= RW'(3) && w_r[0] && w_c >= CW'(3) && w_c[0];
    assign w_last = w_r == R_LAST && w_c == C_LAST;

    always_comb begin
        w_nxt = r_win;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 3; j++) w_nxt[4*i+j] = r_win[4*i+j+1];
            w_nxt[4*i+3] = w_new[i];
        end
    end

    always_ff @(posedge clk) begin
        if (vld_i) begin
            r_lb2[w_c] <= r_lb1[w_c];
            r_lb1[w_c] <= r_lb0[w_c];
            r_lb0[w_c] <= i_pix;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_col        <= '0;
            r_row        <= '0;
            r_win        <= '0;
            vld_o        <= 1'b0;
            o_win        <= '0;
            o_row_idx    <= '0;
            o_col_idx    <= '0;
            o_frame_done <= 1'b0;
        end else begin
            vld_o        <= w_emit;
            o_frame_done <= w_emit && w_last;
            if (vld_i) begin
                r_col <= w_c == C_LAST ? '0 : w_c + CW'(1);
                r_row <= w_c != C_LAST ? w_r : w_r == R_LAST ? '0 : w_r + RW'(1);
                r_win <= w_nxt;
            end else if (i_start) begin
                r_col <= '0;
                r_row <= '0;
            end
            if (w_emit) begin
                o_win     <= w_nxt;
                o_row_idx <= 8'(w_r >> 1) - 8'd1;
                o_col_idx <= 8'(w_c >> 1) - 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_conv_window_gen.sv
// tb_conv_window_gen: drives 8x8, 16x16 and 4x4 instances and checks every cycle
// against a frame-image reference model.
module tb_conv_window_gen;
    logic clk = 0, rstn = 0, vld = 0, start = 0;
    logic [7:0] pix = 0;
    int sel = 0;
    logic         vo [3];
    logic [127:0] wo [3];
    logic [7:0]   ro [3], co [3];
    logic         fo [3];

    always #5 clk = ~clk;

    conv_window_gen #(.IMG_W(8), .IMG_H(8)) u8 (
        .clk(clk), .rstn(rstn), .i_start(start && sel == 0), .vld_i(vld && sel == 0), .i_pix(pix),
        .vld_o(vo[0]), .o_win(wo[0]), .o_row_idx(ro[0]), .o_col_idx(co[0]), .o_frame_done(fo[0]));
    conv_window_gen #(.IMG_W(16), .IMG_H(16)) u16 (
        .clk(clk), .rstn(rstn), .i_start(start && sel == 1), .vld_i(vld && sel == 1), .i_pix(pix),
        .vld_o(vo[1]), .o_win(wo[1]), .o_row_idx(ro[1]), .o_col_idx(co[1]), .o_frame_done(fo[1]));
    conv_window_gen #(.IMG_W(4), .IMG_H(4)) u4 (
        .clk(clk), .rstn(rstn), .i_start(start && sel == 2), .vld_i(vld && sel == 2), .i_pix(pix),
        .vld_o(vo[2]), .o_win(wo[2]), .o_row_idx(ro[2]), .o_col_idx(co[2]), .o_frame_done(fo[2]));

    int nvec = 0, nerr = 0;
    logic [7:0]   img [16][16];
    logic [127:0] hold [3];
    int mr = 0, mc = 0, npix = 0;
    int wins = 0, dones = 0, first_at = 0;
    logic [127:0] first_w, last_w;
    logic [7:0]   first_r, first_c, last_r, last_c;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        wins = 0; dones = 0; npix = 0; first_at = 0;
    endtask

    task automatic cyc(input bit v, input logic [7:0] p, input bit s);
        int w, h, er, ec;
        bit ev, ed;
        w = sel == 0 ? 8 : sel == 1 ? 16 : 4;
        h = w;
        vld = v; pix = p; start = s;
        @(posedge clk);
        if (s) begin mr = 0; mc = 0; end
        ev = 0; ed = 0; er = 0; ec = 0;
        if (v) begin
            img[mr][mc] = p;
            npix++;
            if (mr >= 3 && mr % 2 == 1 && mc >= 3 && mc % 2 == 1) begin
                ev = 1;
                for (int k = 0; k < 16; k++) hold[sel][8*k +: 8] = img[mr-3+k/4][mc-3+k%4];
                er = (mr - 3) / 2;
                ec = (mc - 3) / 2;
                ed = mr == h - 1 && mc == w - 1;
            end
            mc++;
            if (mc == w) begin mc = 0; mr++; if (mr == h) mr = 0; end
        end
        #1;
        chk("vld_o", vo[sel], ev);
        chk("o_win", wo[sel], hold[sel]);
        chk("frame_done", fo[sel], ed);
        if (ev) begin
            chk("row_idx", ro[sel], er);
            chk("col_idx", co[sel], ec);
        end
        if (vo[sel] === 1'b1) begin
            if (wins == 0) begin first_w = wo[sel]; first_at = npix; first_r = ro[sel]; first_c = co[sel]; end
            last_w = wo[sel]; last_r = ro[sel]; last_c = co[sel];
            wins++;
        end
        if (fo[sel] === 1'b1) dones++;
        vld = 0; start = 0;
    endtask

    task automatic chk_zero(input int d);
        chk("rst_vld", vo[d], 0);
        chk("rst_win", wo[d], 0);
        chk("rst_row", ro[d], 0);
        chk("rst_col", co[d], 0);
        chk("rst_done", fo[d], 0);
    endtask

    initial begin
        logic [7:0] px [16];
        logic [127:0] e;
        for (int d = 0; d < 3; d++) hold[d] = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) chk_zero(d);
        rstn = 1;

        // 8x8 ramp, continuous
        sel = 0; clr();
        for (int i = 0; i < 64; i++) cyc(1, 8'(i), 0);
        chk("t1_wins", wins, 9);
        chk("t1_dones", dones, 1);
        chk("t1_first_at", first_at, 28);
        chk("t1_first_din0", first_w[7:0], 0);
        chk("t1_first_din3", first_w[31:24], 3);
        chk("t1_first_din12", first_w[103:96], 24);
        chk("t1_first_din15", first_w[127:120], 27);
        chk("t1_first_idx", {first_r, first_c}, 0);
        chk("t1_last_din0", last_w[7:0], 36);
        chk("t1_last_din15", last_w[127:120], 63);
        chk("t1_last_idx", {last_r, last_c}, {8'd2, 8'd2});

        // 8x8 ramp with 1,0,0 bubble pattern
        clr();
        for (int i = 0; i < 64; i++) begin
            cyc(1, 8'(i), 0);
            cyc(0, 8'($urandom), 0);
            cyc(0, 8'($urandom), 0);
        end
        chk("t2_wins", wins, 9);
        chk("t2_dones", dones, 1);
        chk("t2_last_din15", last_w[127:120], 63);

        // 16x16 two back-to-back random frames with random bubbles
        sel = 1; mr = 0; mc = 0;
        for (int f = 0; f < 2; f++) begin
            clr();
            for (int i = 0; i < 256; i++) begin
                if ($urandom_range(0, 3) == 0) cyc(0, 8'($urandom), 0);
                cyc(1, 8'($urandom), 0);
            end
            chk("t3_wins", wins, 49);
            chk("t3_dones", dones, 1);
        end

        // i_start together with pixel (4,5)
        sel = 0; mr = 0; mc = 0;
        for (int i = 0; i < 37; i++) cyc(1, 8'($urandom), 0);
        clr();
        cyc(1, 8'd0, 1);
        for (int i = 1; i < 64; i++) cyc(1, 8'(i), 0);
        chk("t4_wins", wins, 9);
        chk("t4_dones", dones, 1);
        chk("t4_first_din0", first_w[7:0], 0);
        chk("t4_first_din15", first_w[127:120], 27);

        // asynchronous reset mid-frame at (5,2)
        for (int i = 0; i < 42; i++) cyc(1, 8'($urandom), 0);
        vld = 1; pix = 8'($urandom); rstn = 0;
        #1;
        chk_zero(0);
        @(posedge clk);
        #1;
        chk_zero(0);
        rstn = 1; vld = 0;
        mr = 0; mc = 0; hold[0] = '0; clr();
        cyc(0, 8'd0, 1);
        for (int i = 0; i < 64; i++) cyc(1, 8'($urandom), 0);
        chk("t5_wins", wins, 9);
        chk("t5_dones", dones, 1);

        // 4x4 single window
        sel = 2; mr = 0; mc = 0; clr();
        for (int i = 0; i < 16; i++) begin
            px[i] = 8'($urandom);
            cyc(1, px[i], 0);
        end
        e = '0;
        for (int k = 0; k < 16; k++) e[8*k +: 8] = px[k];
        chk("t6_wins", wins, 1);
        chk("t6_dones", dones, 1);
        chk("t6_win", first_w, e);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/conv_window_gen.md
Name: conv_window_gen

Overview:
- Upstream feeder for the 3x3-conv / ReLU / 2x2-maxpool MAC stage.
- Accepts a raster-order 8-bit pixel stream, one pixel per valid cycle, and buffers the previous three image rows.
- Emits 4x4 pixel windows with stride 2 in both directions: 16 bytes, din0..din15 in row-major order, plus a valid pulse.
- Each window feeds the MAC's 16 data inputs directly; the MAC produces one pooled output per window.

Parameters:
- IMG_W, 16, pixels per row; even, >=4, <=512.
- IMG_H, 16, rows per frame; even, >=4, <=512.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rstn  input  1  asynchronous active-low reset.
- i_start  input  1  single-cycle pulse; next pixel is (row 0, col 0).
- vld_i  input  1  i_pix valid this cycle.
- i_pix  input  8  pixel value.
- vld_o  output  1  o_win valid, single-cycle pulse per window.
- o_win  output  128  window; byte k = o_win[8k+7:8k] = din k, k = 4*wr + wc, wr/wc = 0..3 top-left origin.
- o_row_idx  output  8  output-map row of window, (r-3)/2.
- o_col_idx  output  8  output-map col of window, (c-3)/2.
- o_frame_done  output  1  pulse, same cycle as the last window of the frame.

Behaviour:
- Reset (rstn low, asynchronous): vld_o=0, o_win=0, o_row_idx=0, o_col_idx=0, o_frame_done=0, row/col counters=0, window column registers=0. Line-buffer RAM contents are not reset.
- Counters: col c 0..IMG_W-1, row r 0..IMG_H-1. Advance only on vld_i=1. Col wraps to 0 and increments row at c=IMG_W-1. Row wraps to 0 after the last pixel (IMG_H-1, IMG_W-1), then the next frame starts with no i_start needed.
- Line buffers: three rows, lb0 = row r-1, lb1 = r-2, lb2 = r-3, each indexed by c.
  - On an accepted pixel: read lb2[c], lb1[c], lb0[c]; write lb2[c]<=lb1[c], lb1[c]<=lb0[c], lb0[c]<=i_pix.
  - Read-before-write at the same column within the cycle.
- Window registers: a 4x4 array. On an accepted pixel, columns shift left by one. The new rightmost column is, top to bottom, {lb2[c], lb1[c], lb0[c], i_pix} = rows r-3..r.
- Emit condition, evaluated on the accepted pixel: r>=3, r odd, c>=3, c odd.
  - When met, the next cycle drives vld_o=1 with o_win = pixels rows r-3..r, cols c-3..c.
  - Latency: 1 cycle from the accepting edge.
  - Otherwise vld_o=0 and o_win holds its last value.
- Window counts: per frame, (IMG_H/2-1)*(IMG_W/2-1) windows; 49 for 16x16.
  - Windows never span a row wrap: c>=3 guarantees the column registers hold same-row data.
- o_frame_done=1 together with vld_o for the window at (IMG_H-1, IMG_W-1); 0 otherwise.
- No backpressure. The consumer takes every vld_o pulse. vld_i bubbles only stall the counters and shifting; no output is produced during a bubble.
- i_start: on the next edge, counters go to 0 and the pending output is dropped (vld_o=0 that cycle).
  - i_start together with vld_i: i_start wins for the counters, and the pixel is accepted as (0,0).
  - Line buffers keep stale data, which is harmless because no window is emitted before r=3.
- Reset mid-frame: all state listed under Reset clears immediately. The first pixel after rstn deasserts is (0,0).
- Arithmetic: unsigned 8-bit pixels, no transformation. Index outputs zero-extended to 8 bits.

Test Plan:
- 8x8 frame (IMG_W=IMG_H=8), pixel = 8r+c, vld_i continuous.
  - Exactly 9 vld_o pulses, the first one cycle after pixel (3,3).
  - First o_win bytes: din0=0, din3=3, din12=24, din15=27; idx (0,0).
  - Last window (r=7, c=7): din0=36, din15=63; idx (2,2); o_frame_done=1.
- Same 8x8 frame with vld_i toggling 1,0,0,1,...
  - Identical 9 windows and contents.
  - vld_o exactly one cycle after each qualifying pixel, never during bubble-only cycles.
- Default 16x16, two back-to-back frames with no i_start.
  - 49 windows per frame; o_frame_done twice.
  - Frame-2 first window reflects only frame-2 pixels.
- i_start asserted at pixel (4,5) of a frame, then a full fresh frame.
  - Pixel (4,5) is taken as (0,0); counters restart.
  - Exactly 9 windows (8x8) from the fresh frame, first window din15=27.
- rstn pulsed low mid-frame at (5,2).
  - All outputs 0 asynchronously, with no vld_o during reset.
  - A following full frame yields the correct window count and values.
- IMG_W=4, IMG_H=4: a single window after pixel (3,3), o_frame_done=1, o_win equal to all 16 pixels in order.
